ex_operand_stage: RTL

//  ID/EX pipeline stage directly upstream of the ALU. Registers decoded instructions

---
 rtl/riscv_pkg.sv | 56 +++++
 rtl/ex_fwd_mux.sv | 41 ++++
 rtl/ex_operand_stage.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared types for the ID/EX operand stage: datapath widths, ALU opcode and
// SrcA-select encodings, the registered ID/EX entry, and the RAW-match helper
// used by both the forwarding muxes and the interlock.
// Widths are fixed here (XLEN=32, REG_AW=5) because the entry struct is
// declared in this package.
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // Encoding 11 is a second spelling of rs1.
    typedef enum logic [1:0] {
        SRCA_RS1     = 2'b00,
        SRCA_PC      = 2'b01,
        SRCA_ZERO    = 2'b10,
        SRCA_RS1_ALT = 2'b11
    } srca_sel_e;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        srca_sel_e         srca_sel;
        logic              srcb_sel;
        alu_op_e           op;
        logic              regwrite;
    } id_ex_t;

    // True when a producer writing rd would supply source rs. x0 never matches.
    function automatic logic is_producer(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd,
                                         input logic              we);
        return we && (rs != '0) && (rs == rd);
    endfunction

endpackage

// File: rtl/ex_fwd_mux.sv
// ----------------------------------------------------------------------------
// ex_fwd_mux
// Resolves one source operand: MEM-stage producer first, then WB-stage
// producer, else the stored value. With en low the stored value passes
// through untouched, so an invalid entry never picks up a stray producer.
// Ports:
//   en                          entry is valid
//   rs, stored                  source index and its currently stored value
//   m_rd, m_regwrite, m_result  MEM-stage producer
//   w_rd, w_regwrite, w_result  WB-stage producer
//   value                       resolved operand
// ----------------------------------------------------------------------------
module ex_fwd_mux
    import riscv_pkg::*;
(
    input  logic              en,
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   stored,
    input  logic [REG_AW-1:0] m_rd,
    input  logic              m_regwrite,
    input  logic [XLEN-1:0]   m_result,
    input  logic [REG_AW-1:0] w_rd,
    input  logic              w_regwrite,
    input  logic [XLEN-1:0]   w_result,
    output logic [XLEN-1:0]   value
);

    // NOTE: every always_comb output gets a default first; a path that leaves
    // it unassigned would infer a latch.
    always_comb begin
        value = stored;
        if (en) begin
            if (is_producer(rs, m_rd, m_regwrite)) begin
                value = m_result;
            end else if (is_producer(rs, w_rd, w_regwrite)) begin
                value = w_result;
            end
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ----------------------------------------------------------------------------
// ex_operand_stage
// ID/EX stage in front of the ALU. Decoded entries are taken over a
// valid/ready handshake into a MAIN register (drives the ALU) backed by a
// SKID register, so d_ready can be a flop. RAW hazards on rs1/rs2 are
// resolved from the MEM and WB producers.
//
// Configuration macro EX_FWD_EN:
//   defined   - operands forwarded from MEM/WB; forwarded values are written
//               back into every valid entry each cycle so a stalled entry
//               keeps a producer that has already left the pipe.
//   undefined - stored operands used as-is; e_valid is held low while MAIN
//               reads a register a pending MEM/WB producer is writing.
//
// Ports:
//   clk, reset (async, active-high), flush (sync squash of held entries)
//   d_*          decode-side entry and handshake (d_valid in, d_ready out)
//   m_*, w_*     MEM / WB producers (rd, regwrite, result)
//   e_valid/e_ready  ALU-side handshake
//   SrcA, SrcB, ALUControl          ALU operands and opcode
//   e_rd, e_regwrite, e_pc, e_store_data  passthrough to EX/MEM
// ----------------------------------------------------------------------------
module ex_operand_stage
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic [REG_AW-1:0] d_rd,
    input  logic [XLEN-1:0]   d_rd1,
    input  logic [XLEN-1:0]   d_rd2,
    input  logic [XLEN-1:0]   d_imm,
    input  logic [XLEN-1:0]   d_pc,
    input  logic [1:0]        d_srca_sel,
    input  logic              d_srcb_sel,
    input  logic [3:0]        d_alucontrol,
    input  logic              d_regwrite,
    input  logic [REG_AW-1:0] m_rd,
    input  logic              m_regwrite,
    input  logic [XLEN-1:0]   m_result,
    input  logic [REG_AW-1:0] w_rd,
    input  logic              w_regwrite,
    input  logic [XLEN-1:0]   w_result,
    output logic              e_valid,
    input  logic              e_ready,
    output logic [XLEN-1:0]   SrcA,
    output logic [XLEN-1:0]   SrcB,
    output logic [3:0]        ALUControl,
    output logic [REG_AW-1:0] e_rd,
    output logic              e_regwrite,
    output logic [XLEN-1:0]   e_pc,
    output logic [XLEN-1:0]   e_store_data
);

    id_ex_t          main_q, skid_q, d_entry, main_ref, skid_ref;
    logic            main_valid_q, skid_valid_q, d_ready_q;
    logic            main_valid_n, skid_valid_n;
    logic            load_main_skid, load_main_in, load_skid_in;
    logic            accept, retire, main_free, stall;
    logic [XLEN-1:0] main_fa, main_fb, skid_fa, skid_fb;

    assign d_entry = '{
        rs1:      d_rs1,
        rs2:      d_rs2,
        rd:       d_rd,
        rd1:      d_rd1,
        rd2:      d_rd2,
        imm:      d_imm,
        pc:       d_pc,
        srca_sel: srca_sel_e'(d_srca_sel),
        srcb_sel: d_srcb_sel,
        op:       alu_op_e'(d_alucontrol),
        regwrite: d_regwrite
    };

`ifdef EX_FWD_EN
    ex_fwd_mux u_fwd_main_a (
        .en(main_valid_q), .rs(main_q.rs1), .stored(main_q.rd1),
        .m_rd(m_rd), .m_regwrite(m_regwrite), .m_result(m_result),
        .w_rd(w_rd), .w_regwrite(w_regwrite), .w_result(w_result),
        .value(main_fa)
    );
    ex_fwd_mux u_fwd_main_b (
        .en(main_valid_q), .rs(main_q.rs2), .stored(main_q.rd2),
        .m_rd(m_rd), .m_regwrite(m_regwrite), .m_result(m_result),
        .w_rd(w_rd), .w_regwrite(w_regwrite), .w_result(w_result),
        .value(main_fb)
    );
    ex_fwd_mux u_fwd_skid_a (
        .en(skid_valid_q), .rs(skid_q.rs1), .stored(skid_q.rd1),
        .m_rd(m_rd), .m_regwrite(m_regwrite), .m_result(m_result),
        .w_rd(w_rd), .w_regwrite(w_regwrite), .w_result(w_result),
        .value(skid_fa)
    );
    ex_fwd_mux u_fwd_skid_b (
        .en(skid_valid_q), .rs(skid_q.rs2), .stored(skid_q.rd2),
        .m_rd(m_rd), .m_regwrite(m_regwrite), .m_result(m_result),
        .w_rd(w_rd), .w_regwrite(w_regwrite), .w_result(w_result),
        .value(skid_fb)
    );
    assign stall = 1'b0;
`else
    assign main_fa = main_q.rd1;
    assign main_fb = main_q.rd2;
    assign skid_fa = skid_q.rd1;
    assign skid_fb = skid_q.rd2;
    // Interlock on either source against either producer.
    assign stall = is_producer(main_q.rs1, m_rd, m_regwrite) |
                   is_producer(main_q.rs1, w_rd, w_regwrite) |
                   is_producer(main_q.rs2, m_rd, m_regwrite) |
                   is_producer(main_q.rs2, w_rd, w_regwrite);
    logic unused_results;
    assign unused_results = ^{m_result, w_result};
`endif

    // Refreshed copies of each entry: the resolved operands replace the
    // stored ones at every edge the entry stays (or was last) valid.
    always_comb begin
        main_ref     = main_q;
        main_ref.rd1 = main_fa;
        main_ref.rd2 = main_fb;
        skid_ref     = skid_q;
        skid_ref.rd1 = skid_fa;
        skid_ref.rd2 = skid_fb;
    end

    assign e_valid   = main_valid_q & ~stall;
    assign d_ready   = d_ready_q;
    assign accept    = d_valid & d_ready_q & ~flush;
    assign retire    = e_valid & e_ready;
    assign main_free = ~main_valid_q | retire;

    always_comb begin
        main_valid_n   = main_valid_q;
        skid_valid_n   = skid_valid_q;
        load_main_skid = 1'b0;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                // SKID advances first; a new entry (if any) takes its place.
                load_main_skid = 1'b1;
                main_valid_n   = 1'b1;
                load_skid_in   = accept;
                skid_valid_n   = accept;
            end else begin
                load_main_in = accept;
                main_valid_n = accept;
                skid_valid_n = 1'b0;
            end
        end else if (accept) begin
            load_skid_in = 1'b1;
            skid_valid_n = 1'b1;
        end
    end

    // NOTE: the payload registers are reset too, not only the valid bits,
    // because the operand outputs read them directly and must be 0 after reset.
    // NOTE: state updates use non-blocking assignment so every register in
    // this block samples the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            d_ready_q    <= 1'b0;
        end else begin
            main_valid_q <= main_valid_n;
            skid_valid_q <= skid_valid_n;
            d_ready_q    <= ~skid_valid_n;
            if (load_main_skid) begin
                main_q <= skid_ref;
            end else if (load_main_in) begin
                main_q <= d_entry;
            end else begin
                main_q <= main_ref;
            end
            if (load_skid_in) begin
                skid_q <= d_entry;
            end else begin
                skid_q <= skid_ref;
            end
        end
    end

    always_comb begin
        case (main_q.srca_sel)
            SRCA_PC:   SrcA = main_q.pc;
            SRCA_ZERO: SrcA = '0;
            default:   SrcA = main_fa;
        endcase
    end

    assign SrcB         = main_q.srcb_sel ? main_q.imm : main_fb;
    assign e_store_data = main_fb;
    assign ALUControl   = main_q.op;
    assign e_rd         = main_q.rd;
    assign e_regwrite   = main_q.regwrite;
    assign e_pc         = main_q.pc;

endmodule
